// File: rtl/clock_pkg.sv
// Shared definitions for the clock/alarm slice: ringer state encoding,
// time-field widths shared with the alarm and time core, and counter sizing.
package clock_pkg;

  // Ringer FSM states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RINGING  = 2'd1,
    ST_SNOOZE   = 2'd2,
    ST_WAIT_LOW = 2'd3
  } ringer_state_e;

  // Field widths used by the alarm and the time-keeping core
  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;

  localparam int MS_PER_S = 1000;

  // Number of sec_ticks in one RINGING visit before the beep gate is held open
  localparam int ESC_TICKS = 10;

  // Bits needed to hold values 0..max_count, never less than one bit
  function automatic int cnt_w(input int max_count);
    if (max_count < 2) return 1;
    return $clog2(max_count + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_ringer_tone_gen.sv
// Square-wave tone source: toggles sq every HALF enabled cycles.
// Counter and output are cleared whenever en is low, so every enable
// starts from phase 0 with sq low.
import clock_pkg::*;

module tone_gen #(
  parameter int HALF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sq
);

  localparam int CW = cnt_w(HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sq_q, sq_d;

  // Divider: count 0..HALF-1 and flip the output on wrap
  always_comb begin
    cnt_d = cnt_q;
    sq_d  = sq_q;
    if (!en) begin
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (cnt_q == CW'(HALF - 1)) begin
      cnt_d = '0;
      sq_d  = ~sq_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Divider registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sq_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sq_q  <= sq_d;
    end
  end

  assign sq = sq_q;

endmodule

// File: rtl/alarm_ringer.sv
// Alarm ringer: consumer end of the alarm ring/end_ring handshake.
// Drives a beep-gated square-wave buzzer while ringing, handles stop and
// snooze buttons, times out after TIMEOUT_S seconds.
// Handshake: ring is a level held by the alarm until it sees end_ring;
// end_ring is a single-cycle pulse, issued on stop or timeout only.
// Optional build macro ALARM_RINGER_ESCALATE_EN: after ESC_TICKS seconds in
// one RINGING visit the beep gate is held open (continuous tone).
import clock_pkg::*;

module alarm_ringer #(
  parameter int CLK_FREQ    = 100000000,
  parameter int TONE_HZ     = 2000,
  parameter int BEEP_ON_MS  = 250,
  parameter int BEEP_OFF_MS = 250,
  parameter int TIMEOUT_S   = 60,
  parameter int SNOOZE_S    = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic ring,
  input  logic sec_tick,
  input  logic btn_stop,
  input  logic btn_snooze,
  output logic end_ring,
  output logic buzzer,
  output logic ringing,
  output logic snoozed
);

  localparam int HALF    = CLK_FREQ / (2 * TONE_HZ);
  localparam int ON_CYC  = CLK_FREQ / MS_PER_S * BEEP_ON_MS;
  localparam int OFF_CYC = CLK_FREQ / MS_PER_S * BEEP_OFF_MS;
  localparam int BEEP_W  = cnt_w(max_int(ON_CYC, OFF_CYC) - 1);
  localparam int TO_W    = cnt_w(TIMEOUT_S);
  localparam int SN_W    = cnt_w(SNOOZE_S);
  localparam int SNC_W   = cnt_w(MAX_SNOOZE);

  ringer_state_e state_q, state_d;
  logic [TO_W-1:0]   to_q, to_d;          // seconds in this RINGING visit
  logic [SN_W-1:0]   sn_q, sn_d;          // seconds in current snooze
  logic [SNC_W-1:0]  snc_q, snc_d;        // snoozes used this alarm event
  logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
  logic              gate_on_q, gate_on_d;
  logic              end_ring_q, end_ring_d;
  logic              ringing_q, ringing_d;
  logic              snoozed_q, snoozed_d;
  logic              buzzer_q, buzzer_d;
  logic              enter_ring;
  logic              advance_beep;
  logic              gate_eff;
  logic              tone_sq;

`ifdef ALARM_RINGER_ESCALATE_EN
  localparam int ESC_W = cnt_w(ESC_TICKS);
  logic [ESC_W-1:0]  esc_q, esc_d;
`endif

  // Tone only runs while RINGING; it restarts from phase 0 on every entry
  tone_gen #(
    .HALF (HALF)
  ) u_tone (
    .clk (clk),
    .rst (rst),
    .en  (state_q == ST_RINGING),
    .sq  (tone_sq)
  );

  // Next-state, counters and output values
  always_comb begin
    state_d      = state_q;
    to_d         = to_q;
    sn_d         = sn_q;
    snc_d        = snc_q;
    beep_cnt_d   = beep_cnt_q;
    gate_on_d    = gate_on_q;
    end_ring_d   = 1'b0;
    enter_ring   = 1'b0;
    advance_beep = 1'b0;
`ifdef ALARM_RINGER_ESCALATE_EN
    esc_d        = esc_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (ring) begin
          state_d    = ST_RINGING;
          snc_d      = '0;
          enter_ring = 1'b1;
        end
      end

      // Priority: stop > ring drop > timeout > snooze
      ST_RINGING: begin
        if (btn_stop) begin
          end_ring_d = 1'b1;
          state_d    = ST_WAIT_LOW;
        end else if (!ring) begin
          state_d = ST_IDLE;
        end else if (sec_tick && to_q == TO_W'(TIMEOUT_S - 1)) begin
          end_ring_d = 1'b1;
          state_d    = ST_WAIT_LOW;
        end else begin
          if (sec_tick && to_q != TO_W'(TIMEOUT_S)) to_d = to_q + 1'b1;
          if (btn_snooze && snc_q < SNC_W'(MAX_SNOOZE)) begin
            snc_d   = snc_q + 1'b1;
            sn_d    = '0;
            state_d = ST_SNOOZE;
          end else begin
            advance_beep = 1'b1;
`ifdef ALARM_RINGER_ESCALATE_EN
            if (sec_tick && esc_q != ESC_W'(ESC_TICKS)) esc_d = esc_q + 1'b1;
`endif
          end
        end
      end

      // Snooze keeps ring high at the alarm; only stop or a dropped ring exit early
      ST_SNOOZE: begin
        if (btn_stop) begin
          end_ring_d = 1'b1;
          state_d    = ST_WAIT_LOW;
        end else if (!ring) begin
          state_d = ST_IDLE;
        end else if (sec_tick) begin
          if (sn_q == SN_W'(SNOOZE_S - 1)) begin
            state_d    = ST_RINGING;
            enter_ring = 1'b1;
          end else if (sn_q != SN_W'(SNOOZE_S)) begin
            sn_d = sn_q + 1'b1;
          end
        end
      end

      // Hold off until the alarm has released ring, so it is not re-armed
      ST_WAIT_LOW: begin
        if (!ring) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (advance_beep) begin
      if (gate_on_q) begin
        if (beep_cnt_q == BEEP_W'(ON_CYC - 1)) begin
          beep_cnt_d = '0;
          gate_on_d  = 1'b0;
        end else begin
          beep_cnt_d = beep_cnt_q + 1'b1;
        end
      end else begin
        if (beep_cnt_q == BEEP_W'(OFF_CYC - 1)) begin
          beep_cnt_d = '0;
          gate_on_d  = 1'b1;
        end else begin
          beep_cnt_d = beep_cnt_q + 1'b1;
        end
      end
    end

    if (enter_ring) begin
      to_d       = '0;
      beep_cnt_d = '0;
      gate_on_d  = 1'b1;
`ifdef ALARM_RINGER_ESCALATE_EN
      esc_d      = '0;
`endif
    end

`ifdef ALARM_RINGER_ESCALATE_EN
    gate_eff = gate_on_q | (esc_q == ESC_W'(ESC_TICKS));
`else
    gate_eff = gate_on_q;
`endif

    ringing_d = (state_d == ST_RINGING);
    snoozed_d = (state_d == ST_SNOOZE);
    // Buzzer is silent on the first cycle of a visit and from the cycle RINGING is left
    buzzer_d  = tone_sq & gate_eff & (state_q == ST_RINGING) & (state_d == ST_RINGING);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      to_q       <= '0;
      sn_q       <= '0;
      snc_q      <= '0;
      beep_cnt_q <= '0;
      gate_on_q  <= 1'b0;
      end_ring_q <= 1'b0;
      ringing_q  <= 1'b0;
      snoozed_q  <= 1'b0;
      buzzer_q   <= 1'b0;
`ifdef ALARM_RINGER_ESCALATE_EN
      esc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      to_q       <= to_d;
      sn_q       <= sn_d;
      snc_q      <= snc_d;
      beep_cnt_q <= beep_cnt_d;
      gate_on_q  <= gate_on_d;
      end_ring_q <= end_ring_d;
      ringing_q  <= ringing_d;
      snoozed_q  <= snoozed_d;
      buzzer_q   <= buzzer_d;
`ifdef ALARM_RINGER_ESCALATE_EN
      esc_q      <= esc_d;
`endif
    end
  end

  assign end_ring = end_ring_q;
  assign buzzer   = buzzer_q;
  assign ringing  = ringing_q;
  assign snoozed  = snoozed_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// Bench for alarm_ringer: directed scenarios followed by randomized
// ring/button traffic, every cycle compared against a behavioural model.
module tb_alarm_ringer;

  localparam int CLK_FREQ    = 1000;
  localparam int TONE_HZ     = 100;
  localparam int BEEP_MS     = 20;
  localparam int SNOOZE_S    = 3;
  localparam int MAX_SNOOZE  = 2;
  localparam int TICK_PERIOD = 50;
  localparam int HALF        = CLK_FREQ / (2 * TONE_HZ);
  localparam int ON_CYC      = CLK_FREQ / 1000 * BEEP_MS;
  localparam int OFF_CYC     = CLK_FREQ / 1000 * BEEP_MS;
  localparam int ESC_TICKS   = 10;
`ifdef ALARM_RINGER_ESCALATE_EN
  localparam int TIMEOUT_S   = 14;
  localparam bit ESC_ON      = 1'b1;
`else
  localparam int TIMEOUT_S   = 4;
  localparam bit ESC_ON      = 1'b0;
`endif

  localparam int M_IDLE = 0, M_RING = 1, M_SNZ = 2, M_WAIT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ring = 1'b0;
  logic sec_tick = 1'b0;
  logic btn_stop = 1'b0;
  logic btn_snooze = 1'b0;
  logic end_ring, buzzer, ringing, snoozed;

  always #5 clk = ~clk;

  alarm_ringer #(
    .CLK_FREQ    (CLK_FREQ),
    .TONE_HZ     (TONE_HZ),
    .BEEP_ON_MS  (BEEP_MS),
    .BEEP_OFF_MS (BEEP_MS),
    .TIMEOUT_S   (TIMEOUT_S),
    .SNOOZE_S    (SNOOZE_S),
    .MAX_SNOOZE  (MAX_SNOOZE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ring       (ring),
    .sec_tick   (sec_tick),
    .btn_stop   (btn_stop),
    .btn_snooze (btn_snooze),
    .end_ring   (end_ring),
    .buzzer     (buzzer),
    .ringing    (ringing),
    .snoozed    (snoozed)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc_idx  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_idx);
  endtask

  // ---------------- reference model ----------------
  // Mode plus time-since-entry; buzzer is derived arithmetically from the
  // number of cycles spent in the current RINGING visit.
  int   m_mode     = M_IDLE;
  int   m_secs     = 0;
  int   m_snz_secs = 0;
  int   m_snoozes  = 0;
  int   m_start    = 0;
  int   m_esc_at   = -1;
  int   m_k;
  logic m_end      = 1'b0;
  logic m_buz      = 1'b0;
  logic m_esc;

  task m_enter_ring();
    m_mode   = M_RING;
    m_start  = cyc_idx;
    m_secs   = 0;
    m_esc_at = -1;
  endtask

  always @(posedge clk) begin
    cyc_idx++;
    m_end = 1'b0;
    if (rst) begin
      m_mode     = M_IDLE;
      m_secs     = 0;
      m_snz_secs = 0;
      m_snoozes  = 0;
      m_esc_at   = -1;
    end else begin
      case (m_mode)
        M_IDLE: if (ring) begin m_enter_ring(); m_snoozes = 0; end
        M_RING: begin
          if (btn_stop) begin m_end = 1'b1; m_mode = M_WAIT; end
          else if (!ring) m_mode = M_IDLE;
          else begin
            if (sec_tick) m_secs++;
            if (m_secs == TIMEOUT_S) begin m_end = 1'b1; m_mode = M_WAIT; end
            else begin
              if (sec_tick && m_secs == ESC_TICKS) m_esc_at = cyc_idx;
              if (btn_snooze && m_snoozes < MAX_SNOOZE) begin
                m_snoozes++;
                m_snz_secs = 0;
                m_mode = M_SNZ;
              end
            end
          end
        end
        M_SNZ: begin
          if (btn_stop) begin m_end = 1'b1; m_mode = M_WAIT; end
          else if (!ring) m_mode = M_IDLE;
          else if (sec_tick) begin
            m_snz_secs++;
            if (m_snz_secs == SNOOZE_S) m_enter_ring();
          end
        end
        default: if (!ring) m_mode = M_IDLE;
      endcase
    end
    m_k   = cyc_idx - m_start - 1;
    m_esc = ESC_ON && (m_esc_at >= 0) && (cyc_idx - 1 >= m_esc_at);
    m_buz = (m_mode == M_RING) && (m_k >= 0) && (((m_k / HALF) % 2) == 1) &&
            (((m_k % (ON_CYC + OFF_CYC)) < ON_CYC) || m_esc);
  end

  // Per-cycle comparison against the model, away from the active edge
  logic mon_en  = 1'b0;
  int   end_seen = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("ringing", ringing, m_mode == M_RING);
      check("snoozed", snoozed, m_mode == M_SNZ);
      check("end_ring", end_ring, m_end);
      check("buzzer", buzzer, m_buz);
      if (end_ring === 1'b1) end_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  int tick_div = 0;

  task automatic step(input logic s, input logic z);
    btn_stop   = s;
    btn_snooze = z;
    sec_tick   = (tick_div == TICK_PERIOD - 1);
    tick_div   = (tick_div == TICK_PERIOD - 1) ? 0 : tick_div + 1;
    @(negedge clk);
    btn_stop   = 1'b0;
    btn_snooze = 1'b0;
    sec_tick   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic wait_ringing(input string tag, input int limit);
    int i;
    i = 0;
    while (ringing !== 1'b1 && i < limit) begin
      step(1'b0, 1'b0);
      i++;
    end
    check(tag, ringing, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    int bound;
    logic s, z;

    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    check("rst_ringing", ringing, 0);
    check("rst_buzzer", buzzer, 0);
    check("rst_end_ring", end_ring, 0);
    check("rst_snoozed", snoozed, 0);
    rst = 1'b0;
    idle(3);

    // Basic ring and stop
    ring = 1'b1;
    step(1'b0, 1'b0);
    check("ring_rise", ringing, 1);
    idle(100);
    end_seen = 0;
    step(1'b1, 1'b0);
    check("stop_end_ring", end_ring, 1);
    check("stop_ringing", ringing, 0);
    ring = 1'b0;
    idle(5);
    check("stop_one_pulse", end_seen, 1);

    // Timeout with no buttons
    ring = 1'b1;
    end_seen = 0;
    bound = 0;
    while (end_seen == 0 && bound < TIMEOUT_S * TICK_PERIOD + 100) begin
      step(1'b0, 1'b0);
      bound++;
    end
    idle(20);
    check("timeout_pulses", end_seen, 1);
    check("timeout_buzzer", buzzer, 0);
    ring = 1'b0;
    idle(3);

    // Snooze twice, third snooze ignored
    ring = 1'b1;
    idle(12);
    step(1'b0, 1'b1);
    check("snz1_snoozed", snoozed, 1);
    check("snz1_end_ring", end_ring, 0);
    check("snz1_buzzer", buzzer, 0);
    wait_ringing("snz1_resume", 250);
    idle(10);
    step(1'b0, 1'b1);
    check("snz2_snoozed", snoozed, 1);
    wait_ringing("snz2_resume", 250);
    idle(10);
    step(1'b0, 1'b1);
    check("snz3_ignored", ringing, 1);
    check("snz3_not_snoozed", snoozed, 0);
    step(1'b1, 1'b0);
    ring = 1'b0;
    idle(3);

    // Stop and snooze together
    ring = 1'b1;
    idle(15);
    step(1'b1, 1'b1);
    check("both_end_ring", end_ring, 1);
    check("both_snoozed", snoozed, 0);
    check("both_ringing", ringing, 0);
    ring = 1'b0;
    idle(3);

    // Ring dropped by the alarm mid-ringing
    ring = 1'b1;
    idle(27);
    ring = 1'b0;
    step(1'b0, 1'b0);
    check("drop_ringing", ringing, 0);
    check("drop_buzzer", buzzer, 0);
    check("drop_end_ring", end_ring, 0);
    idle(3);

    // Reset while ringing with ring held high
    ring = 1'b1;
    idle(33);
    rst = 1'b1;
    step(1'b0, 1'b0);
    check("rst_mid_ringing", ringing, 0);
    check("rst_mid_buzzer", buzzer, 0);
    rst = 1'b0;
    step(1'b0, 1'b0);
    check("rst_reenter", ringing, 1);
    idle(40);
    step(1'b1, 1'b0);
    ring = 1'b0;
    idle(3);

`ifdef ALARM_RINGER_ESCALATE_EN
    // Continuous tone after ESC_TICKS seconds of ringing
    ring = 1'b1;
    idle((ESC_TICKS + 1) * TICK_PERIOD + 10);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (buzzer === 1'b1) cnt++;
      step(1'b0, 1'b0);
    end
    check("esc_continuous", cnt, 20);
    idle(200);
    ring = 1'b0;
    idle(3);
`endif

    // Randomized ring / button traffic
    for (int i = 0; i < 4000; i++) begin
      if (ring && $urandom_range(0, 999) < 4) ring = 1'b0;
      else if (!ring && $urandom_range(0, 999) < 60) ring = 1'b1;
      s = ($urandom_range(0, 59) == 0);
      z = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 1999) == 0);
      step(s, z);
      rst = 1'b0;
    end

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
